// File: rtl/nn_pkg.sv
// Shared types and constants for the output-neuron result path.
// State encoding, node limits and the signed 8-bit score range.
package nn_pkg;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    DONE
  } state_e;

  localparam int MAX_NODES = 16;

  localparam logic signed [7:0] RESULT_MIN = -8'sd128;
  localparam logic signed [7:0] RESULT_MAX = 8'sd127;

  // A node count field of zero stands for the full sixteen nodes.
  function automatic logic [4:0] decode_n(input logic [3:0] n);
    return (n == 4'd0) ? 5'd16 : {1'b0, n};
  endfunction

endpackage

// File: rtl/requantize_sat.sv
// Arithmetic right shift of a raw accumulator, then clamp to int8.
// Purely combinational; sign is carried through the shift.
module requantize_sat
  import nn_pkg::*;
#(
  parameter int ACC_W = 16,
  parameter int SHIFT = 4
) (
  input  logic [ACC_W-1:0] acc_i,
  output logic [7:0]       res_o
);

  localparam logic signed [ACC_W-1:0] HI = ACC_W'(127);
  localparam logic signed [ACC_W-1:0] LO = ACC_W'(-128);

  logic signed [ACC_W-1:0] sh;

  assign sh = $signed(acc_i) >>> SHIFT;

  always_comb begin
    res_o = sh[7:0];
    if (sh > HI) begin
      res_o = RESULT_MAX;
    end else if (sh < LO) begin
      res_o = RESULT_MIN;
    end
  end

endmodule

// File: rtl/result_collector.sv
// Gathers N requantized output-node scores in order and holds them
// for the classifier until the next start.
module result_collector
  import nn_pkg::*;
#(
  parameter int ACC_W = 16,
  parameter int SHIFT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       outputNodeNumber,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [ACC_W-1:0] in_acc,
  output logic [7:0]       result0,
  output logic [7:0]       result1,
  output logic [7:0]       result2,
  output logic [7:0]       result3,
  output logic [7:0]       result4,
  output logic [7:0]       result5,
  output logic [7:0]       result6,
  output logic [7:0]       result7,
  output logic [7:0]       result8,
  output logic [7:0]       result9,
  output logic [7:0]       result10,
  output logic [7:0]       result11,
  output logic [7:0]       result12,
  output logic [7:0]       result13,
  output logic [7:0]       result14,
  output logic [7:0]       result15,
  output logic [4:0]       count,
  output logic             busy,
  output logic             done,
  output logic             results_valid
);

  state_e      state_q;
  logic [4:0]  n_q;
  logic [4:0]  count_q;
  logic [4:0]  count_d;
  logic        done_q;
  logic [7:0]  res_q [MAX_NODES];
  logic [7:0]  rq;
  logic        xfer;

  requantize_sat #(
    .ACC_W (ACC_W),
    .SHIFT (SHIFT)
  ) u_rq (
    .acc_i (in_acc),
    .res_o (rq)
  );

  assign in_ready = (state_q == COLLECT) && (count_q < n_q);
  assign xfer     = in_valid && in_ready;
  assign count_d  = count_q + 5'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      n_q     <= 5'd0;
      count_q <= 5'd0;
      done_q  <= 1'b0;
      for (int i = 0; i < MAX_NODES; i++) begin
        res_q[i] <= RESULT_MIN;
      end
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q <= COLLECT;
            n_q     <= decode_n(outputNodeNumber);
            count_q <= 5'd0;
            for (int i = 0; i < MAX_NODES; i++) begin
              res_q[i] <= RESULT_MIN;
            end
          end
        end
        COLLECT: begin
          if (xfer) begin
            res_q[count_q[3:0]] <= rq;
            count_q             <= count_d;
            // Final node closes the collection on this same edge.
            if (count_d == n_q) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign count         = count_q;
  assign busy          = (state_q == COLLECT);
  assign done          = done_q;
  assign results_valid = (state_q == DONE);

  assign result0  = res_q[0];
  assign result1  = res_q[1];
  assign result2  = res_q[2];
  assign result3  = res_q[3];
  assign result4  = res_q[4];
  assign result5  = res_q[5];
  assign result6  = res_q[6];
  assign result7  = res_q[7];
  assign result8  = res_q[8];
  assign result9  = res_q[9];
  assign result10 = res_q[10];
  assign result11 = res_q[11];
  assign result12 = res_q[12];
  assign result13 = res_q[13];
  assign result14 = res_q[14];
  assign result15 = res_q[15];

endmodule

// File: tb/tb_result_collector.sv
// Self-checking bench for result_collector: directed vectors,
// corner sequences and randomized collections against a model.
module tb_result_collector;

  localparam int ACC_W = 16;
  localparam int SHIFT = 4;

  typedef struct {
    int acc;
    int res;
  } vec_t;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic [3:0]       onn = 4'd0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [ACC_W-1:0] in_acc = '0;
  logic [7:0]       r [16];
  logic [4:0]       count;
  logic             busy;
  logic             done;
  logic             rv;

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  result_collector #(
    .ACC_W (ACC_W),
    .SHIFT (SHIFT)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .outputNodeNumber (onn),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_acc           (in_acc),
    .result0          (r[0]),
    .result1          (r[1]),
    .result2          (r[2]),
    .result3          (r[3]),
    .result4          (r[4]),
    .result5          (r[5]),
    .result6          (r[6]),
    .result7          (r[7]),
    .result8          (r[8]),
    .result9          (r[9]),
    .result10         (r[10]),
    .result11         (r[11]),
    .result12         (r[12]),
    .result13         (r[13]),
    .result14         (r[14]),
    .result15         (r[15]),
    .count            (count),
    .busy             (busy),
    .done             (done),
    .results_valid    (rv)
  );

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // Floor division by 2^SHIFT, then clamp to the int8 range.
  function automatic int model(input int a);
    int d;
    int q;
    d = 1 << SHIFT;
    q = a / d;
    if (a < 0 && (a % d) != 0) q = q - 1;
    if (q > 127) return 127;
    if (q < -128) return -128;
    return q;
  endfunction

  function automatic int rs(input int k);
    return int'($signed(r[k]));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_col(input int n);
    onn = 4'(n);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic xfer(input int a);
    in_valid = 1'b1;
    in_acc = ACC_W'(a);
    tick();
    in_valid = 1'b0;
  endtask

  vec_t tbl [16];
  int   exp_r [16];

  initial begin
    tbl[0]  = '{160, 10};
    tbl[1]  = '{-48, -3};
    tbl[2]  = '{4000, 127};
    tbl[3]  = '{-32768, -128};
    tbl[4]  = '{32767, 127};
    tbl[5]  = '{-1, -1};
    tbl[6]  = '{0, 0};
    tbl[7]  = '{16, 1};
    tbl[8]  = '{2032, 127};
    tbl[9]  = '{2047, 127};
    tbl[10] = '{2048, 127};
    tbl[11] = '{-2048, -128};
    tbl[12] = '{-2049, -128};
    tbl[13] = '{-2047, -128};
    tbl[14] = '{-17, -2};
    tbl[15] = '{15, 0};

    // Reset state
    reset = 1'b1;
    tick();
    tick();
    chk("rst_count", int'(count), 0);
    chk("rst_ready", int'(in_ready), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_rv", int'(rv), 0);
    chk("rst_r0", rs(0), -128);
    chk("rst_r15", rs(15), -128);
    reset = 1'b0;
    tick();

    // N=3 back-to-back
    start_col(3);
    chk("s1_busy", int'(busy), 1);
    chk("s1_ready", int'(in_ready), 1);
    chk("s1_count0", int'(count), 0);
    xfer(160);
    xfer(-48);
    chk("s1_nodone", int'(done), 0);
    xfer(4000);
    chk("s1_done", int'(done), 1);
    chk("s1_rv", int'(rv), 1);
    chk("s1_count", int'(count), 3);
    chk("s1_ready_off", int'(in_ready), 0);
    chk("s1_busy_off", int'(busy), 0);
    chk("s1_r0", rs(0), 10);
    chk("s1_r1", rs(1), -3);
    chk("s1_r2", rs(2), 127);
    for (int k = 3; k < 16; k++) chk($sformatf("s1_r%0d", k), rs(k), -128);
    tick();
    chk("s1_done_pulse", int'(done), 0);
    chk("s1_rv_hold", int'(rv), 1);
    xfer(16);
    chk("s1_idle_valid_count", int'(count), 3);
    chk("s1_idle_valid_r0", rs(0), 10);
    chk("s1_idle_valid_r3", rs(3), -128);

    // Requantization table, 16 nodes back-to-back
    start_col(0);
    for (int i = 0; i < 16; i++) xfer(tbl[i].acc);
    chk("tbl_count", int'(count), 16);
    chk("tbl_ready", int'(in_ready), 0);
    chk("tbl_done", int'(done), 1);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("tbl_acc_%0d", tbl[i].acc), rs(i), tbl[i].res);
    end

    // 16 nodes with random valid gaps
    begin
      int k;
      int guard;
      k = 0;
      guard = 0;
      start_col(0);
      while (k < 16 && guard < 400) begin
        if ($urandom_range(0, 1) == 1) begin
          xfer(16 * k);
          k++;
        end else begin
          tick();
        end
        guard++;
      end
      chk("gap_transfers", k, 16);
      chk("gap_count", int'(count), 16);
      chk("gap_ready", int'(in_ready), 0);
      for (int i = 0; i < 16; i++) chk($sformatf("gap_r%0d", i), rs(i), i);
    end

    // start and N change mid-collection are ignored
    start_col(5);
    xfer(16);
    xfer(32);
    in_valid = 1'b1;
    in_acc = ACC_W'(48);
    start = 1'b1;
    onn = 4'd2;
    tick();
    start = 1'b0;
    in_valid = 1'b0;
    chk("mid_busy", int'(busy), 1);
    chk("mid_count", int'(count), 3);
    chk("mid_r2", rs(2), 3);
    onn = 4'd9;
    xfer(64);
    chk("mid_nodone", int'(done), 0);
    chk("mid_count4", int'(count), 4);
    xfer(80);
    chk("mid_done", int'(done), 1);
    chk("mid_count5", int'(count), 5);
    chk("mid_r0", rs(0), 1);
    chk("mid_r4", rs(4), 5);
    chk("mid_r5", rs(5), -128);

    // Reset abandons a collection
    start_col(4);
    xfer(16);
    xfer(32);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("ab_r0", rs(0), -128);
    chk("ab_r1", rs(1), -128);
    chk("ab_busy", int'(busy), 0);
    chk("ab_rv", int'(rv), 0);
    chk("ab_done", int'(done), 0);
    chk("ab_count", int'(count), 0);
    chk("ab_ready", int'(in_ready), 0);
    tick();
    chk("ab_done2", int'(done), 0);
    start_col(2);
    xfer(-160);
    xfer(320);
    chk("ab_new_done", int'(done), 1);
    chk("ab_new_r0", rs(0), -10);
    chk("ab_new_r1", rs(1), 20);

    // start with in_valid while in DONE
    onn = 4'd1;
    start = 1'b1;
    in_valid = 1'b1;
    in_acc = ACC_W'(800);
    tick();
    start = 1'b0;
    in_valid = 1'b0;
    chk("rs_busy", int'(busy), 1);
    chk("rs_rv", int'(rv), 0);
    chk("rs_count", int'(count), 0);
    chk("rs_r0", rs(0), -128);
    chk("rs_r1", rs(1), -128);
    chk("rs_done", int'(done), 0);
    chk("rs_ready", int'(in_ready), 1);
    xfer(800);
    chk("rs_fin_done", int'(done), 1);
    chk("rs_fin_r0", rs(0), 50);

    // Randomized collections against the model
    for (int t = 0; t < 25; t++) begin
      int n;
      int nn;
      int sent;
      int guard;
      int a;
      bit v;
      logic signed [15:0] raw;
      n = $urandom_range(0, 15);
      nn = (n == 0) ? 16 : n;
      for (int i = 0; i < 16; i++) exp_r[i] = -128;
      start_col(n);
      sent = 0;
      guard = 0;
      while (sent < nn && guard < 400) begin
        v = ($urandom_range(0, 2) != 0);
        if ($urandom_range(0, 3) == 0) begin
          raw = 16'($urandom);
          a = int'(raw);
        end else begin
          a = $urandom_range(0, 4400) - 2200;
        end
        in_valid = v;
        in_acc = ACC_W'(a);
        start = ($urandom_range(0, 7) == 0);
        onn = 4'($urandom);
        chk($sformatf("rnd%0d_ready", t), int'(in_ready), 1);
        tick();
        in_valid = 1'b0;
        start = 1'b0;
        if (v) begin
          exp_r[sent] = model(a);
          sent++;
        end
        guard++;
      end
      chk($sformatf("rnd%0d_sent", t), sent, nn);
      chk($sformatf("rnd%0d_done", t), int'(done), 1);
      chk($sformatf("rnd%0d_rv", t), int'(rv), 1);
      chk($sformatf("rnd%0d_count", t), int'(count), nn);
      chk($sformatf("rnd%0d_ready_off", t), int'(in_ready), 0);
      for (int i = 0; i < 16; i++) begin
        chk($sformatf("rnd%0d_r%0d", t, i), rs(i), exp_r[i]);
      end
      tick();
      chk($sformatf("rnd%0d_pulse", t), int'(done), 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/result_collector.md
RESULT_COLLECTOR -- requirements
Module: result_collector

Interface
REQ-001 SHALL have parameter ACC_W, default 16: width of the signed raw output-neuron accumulator.
REQ-002 SHALL have parameter SHIFT, default 4: arithmetic right-shift applied before saturation, range 0..ACC_W-8.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  begin a new collection; single-cycle pulse.
REQ-006 SHALL have port outputNodeNumber  input  4  number of output nodes N; 0 encodes 16.
REQ-007 SHALL have port in_valid  input  1  in_acc holds a valid accumulator value.
REQ-008 SHALL have port in_ready  output  1  the block accepts in_acc this cycle.
REQ-009 SHALL have port in_acc  input  ACC_W  signed accumulator for the next output node, in node order.
REQ-010 SHALL have ports result0..result15  output  8 each  signed requantized node scores, feeding the classifier.
REQ-011 SHALL have port count  output  5  number of nodes accepted in the current collection, 0..16.
REQ-012 SHALL have port busy  output  1  high in COLLECT.
REQ-013 SHALL have port done  output  1  one-cycle pulse on the cycle after the Nth transfer.
REQ-014 SHALL have port results_valid  output  1  high in DONE; result0..15 are stable and complete.

Function
REQ-015 SHALL implement FSM states IDLE, COLLECT, DONE.
REQ-016 IDLE: start -> COLLECT. In the same edge: latch N (0 -> 16), set count=0, set all results to -128.
REQ-017 DONE: start SHALL behave exactly as in IDLE. Without start, DONE SHALL hold indefinitely.
REQ-018 in_ready SHALL be 1 exactly when state==COLLECT and count<N, as a registered-state decode.
REQ-019 Transfer occurs when in_valid && in_ready. result[count] SHALL take the requantized value and count SHALL increment on that edge.
REQ-020 Requantize: arithmetic shift in_acc right by SHIFT, then saturate to [-128,+127]. Sign SHALL be preserved and there SHALL be no wrap-around.
REQ-021 The transfer that makes count==N SHALL move the state to DONE on the same edge. done SHALL be 1 for exactly the following cycle.
REQ-022 Accumulators are written in order 0..N-1. result[k] for k>=N SHALL remain -128.
REQ-023 start during COLLECT SHALL be ignored. Collection continues.
REQ-024 in_valid outside COLLECT SHALL be ignored. No result or count change.
REQ-025 in_valid held across consecutive cycles SHALL give one transfer per cycle (full throughput, zero bubbles).
REQ-026 Results SHALL change only on a transfer, a start or a reset.
REQ-027 N latched at start SHALL be used for the whole collection. Changes to outputNodeNumber mid-collection have no effect.

Reset
REQ-028 reset SHALL take priority over all other inputs.
REQ-029 On reset: state=IDLE, count=0, all results=-128, in_ready=0, busy=0, done=0, results_valid=0.
REQ-030 reset asserted mid-COLLECT SHALL abandon the collection. No done pulse.

Structure
REQ-031 Shared package nn_pkg SHALL hold the state enum (IDLE/COLLECT/DONE), the constant MAX_NODES=16, RESULT_MIN=-128 and RESULT_MAX=127.
REQ-032 The shift-and-saturate SHALL be a combinational sub-module requantize_sat, parameterized by ACC_W and SHIFT.
REQ-033 result0..15 SHALL be held internally as a 16-entry array and mapped to the discrete ports.

Verification
REQ-034 Scenario: reset, start with N=3, stream in_acc 160, -48, 4000 back-to-back -> result0=10, result1=-3, result2=127, result3..15=-128, done one cycle after the 3rd transfer.
REQ-035 Scenario: N=0 (16 nodes), stream in_acc = 16*k for k=0..15 with random in_valid gaps -> resultk=k, count=16, in_ready=0 after the 16th transfer.
REQ-036 Scenario: saturation, in_acc=-32768 and +32767 with SHIFT=4 -> -128 and +127. in_acc=-1 -> -1 (arithmetic shift).
REQ-037 Scenario: start asserted during COLLECT after 2 of 5 nodes -> ignored, collection completes at count=5. Change outputNodeNumber mid-run -> no effect.
REQ-038 Scenario: reset asserted after 2 of 4 transfers -> all results -128, state IDLE, no done. A new start then completes normally.
REQ-039 Scenario: in DONE, start and in_valid in the same cycle -> no transfer, results cleared to -128, state COLLECT, count=0.
